// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: loads operands A, B and opcode F one at a time from
// a shared 3-bit switch field. Each accepted step press loads one field.
// The held values are flagged valid for the downstream ALU stage.
// The step input and the switch field are synchronized, and step is debounced.
// Optional feature macro: SEQ_TIMEOUT_EN. When it is defined, a partial entry
// left idle in LOAD_B or LOAD_F for TIMEOUT_CYCLES cycles is abandoned.
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 200
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [2:0] sw_data,
    input  logic       step,
    output logic [2:0] a_out,
    output logic [2:0] b_out,
    output logic [1:0] f_out,
    output logic       operands_valid,
    output logic [3:0] state_led
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        LOAD_F = 2'd2,
        READY  = 2'd3
    } state_t;

    logic             step_m_q, step_s_q;
    logic [2:0]       data_m_q, data_s_q;
    logic             step_f_q, step_f_d, step_f_dly_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             step_p;
    state_t           state_q, state_d;
    logic [2:0]       a_q, a_d, b_q, b_d;
    logic [1:0]       f_q, f_d;
    logic             valid_q, valid_d;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Two-flop synchronizers for the raw step level and the switch field.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            step_m_q <= 1'b0;
            step_s_q <= 1'b0;
            data_m_q <= 3'd0;
            data_s_q <= 3'd0;
        end else begin
            step_m_q <= step;
            step_s_q <= step_m_q;
            data_m_q <= sw_data;
            data_s_q <= data_m_q;
        end
    end

    // Debounce: the synchronized level must hold DEBOUNCE_CYCLES cycles before the filtered level follows it.
    always_comb begin
        step_f_d  = step_f_q;
        deb_cnt_d = deb_cnt_q;
        if (step_s_q == step_f_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            step_f_d  = ~step_f_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // One-cycle pulse on each accepted rising level of the filtered step.
    assign step_p = step_f_q & ~step_f_dly_q;

    // Next-state and capture logic for the entry sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        unique case (state_q)
            LOAD_A: if (step_p) begin a_d = data_s_q;      state_d = LOAD_B; end
            LOAD_B: if (step_p) begin b_d = data_s_q;      state_d = LOAD_F; end
            LOAD_F: if (step_p) begin f_d = data_s_q[1:0]; state_d = READY;  end
            READY:  if (step_p) begin                      state_d = LOAD_A; end
        endcase
`ifdef SEQ_TIMEOUT_EN
        // The counter only runs while an entry is partially made; a step resets it.
        tmo_cnt_d = tmo_cnt_q;
        if (step_p || !((state_q == LOAD_B) || (state_q == LOAD_F))) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_cnt_d = '0;
            state_d   = LOAD_A;
            a_d       = 3'd0;
            b_d       = 3'd0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
        valid_d = (state_d == READY);
    end

    // State, debounce and output registers; everything clears on reset.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            step_f_q     <= 1'b0;
            step_f_dly_q <= 1'b0;
            deb_cnt_q    <= '0;
            state_q      <= LOAD_A;
            a_q          <= 3'd0;
            b_q          <= 3'd0;
            f_q          <= 2'd0;
            valid_q      <= 1'b0;
        end else begin
            step_f_q     <= step_f_d;
            step_f_dly_q <= step_f_q;
            deb_cnt_q    <= deb_cnt_d;
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            f_q          <= f_d;
            valid_q      <= valid_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Idle-timeout counter register.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    // One-hot LED decode of the current state.
    always_comb begin
        state_led = 4'b0001;
        unique case (state_q)
            LOAD_A: state_led = 4'b0001;
            LOAD_B: state_led = 4'b0010;
            LOAD_F: state_led = 4'b0100;
            READY:  state_led = 4'b1000;
        endcase
    end

    assign a_out          = a_q;
    assign b_out          = b_q;
    assign f_out          = f_q;
    assign operands_valid = valid_q;

endmodule
